psum_ctrl: RTL and testbench

PSUM_CTRL -- requirements
Module: psum_ctrl

---
 rtl/psum_ctrl_pkg.sv | 15 +
 rtl/psum_ctrl.sv | 159 +++++++++++++++
 tb/tb_psum_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/psum_ctrl_pkg.sv
// Shared definitions for the partial-sum accumulation controller.
package psum_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      ACCUM,
      FLUSH,
      DRAIN,
      FIN
   } state_t;

   localparam int unsigned FLUSH_LAT = 3;

endpackage

// File: rtl/psum_ctrl.sv
// Partial-sum FIFO controller: zero-fills, accumulates passes per tile and drains the
// finished FIFO in ping-pong fashion while the next tile accumulates.
module psum_ctrl
   import psum_ctrl_pkg::*;
#(
   parameter int unsigned ROW_LEN = 16,
   parameter int unsigned PASS_W  = 8,
   parameter int unsigned TILE_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [PASS_W-1:0] cfg_passes,
   input  logic [TILE_W-1:0] cfg_tiles,
   input  logic              pe_valid,
   output logic              pe_ready,
   output logic              p_init,
   output logic              p_valid_data,
   output logic              p_write_zero,
   output logic              odd_cnt,
   output logic              busy,
   output logic              tile_done,
   output logic              done
);

   localparam int unsigned    CW       = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
   localparam logic [CW-1:0]  COL_LAST = CW'(ROW_LEN - 1);
   localparam logic [1:0]     FL_LAST  = 2'(FLUSH_LAT - 1);

   state_t              r_state, w_state_nxt;
   logic [CW-1:0]       r_col;
   logic [PASS_W-1:0]   r_pass, r_cfg_passes;
   logic [TILE_W-1:0]   r_tile, r_cfg_tiles;
   logic [1:0]          r_flush;
   logic                r_odd, r_tile_done, r_done;
   logic                r_drain_active;
   logic [CW-1:0]       r_drain_cnt;

   logic [PASS_W-1:0]   w_passes_m1;
   logic [TILE_W-1:0]   w_tiles_m1;
   logic                w_col_last, w_pass_last, w_tile_last, w_flush_end;
   logic                w_drain_last, w_tile_step;

   // A zero configuration behaves as one pass / one tile.
   assign w_passes_m1  = (r_cfg_passes == '0) ? '0 : r_cfg_passes - PASS_W'(1);
   assign w_tiles_m1   = (r_cfg_tiles  == '0) ? '0 : r_cfg_tiles  - TILE_W'(1);
   assign w_col_last   = (r_col == COL_LAST);
   assign w_pass_last  = (r_pass == w_passes_m1);
   assign w_tile_last  = (r_tile == w_tiles_m1);
   assign w_flush_end  = (r_flush == FL_LAST);
   assign w_drain_last = r_drain_active && (r_drain_cnt == COL_LAST);

   assign pe_ready     = (r_state == ACCUM);
   assign p_init       = (r_state == INIT);
   assign p_valid_data = pe_valid & pe_ready;
   assign p_write_zero = r_drain_active;
   assign odd_cnt      = r_odd;
   assign busy         = (r_state != IDLE);
   assign tile_done    = r_tile_done;
   assign done         = r_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tile_step = 1'b0;
      case (r_state)
         IDLE:  if (start) w_state_nxt = INIT;
         INIT:  if (w_col_last) w_state_nxt = ACCUM;
         ACCUM: if (p_valid_data && w_col_last && w_pass_last) w_state_nxt = FLUSH;
         FLUSH: begin
            // A pending tile_done means the previous drain starts next cycle.
            if (w_flush_end && !r_drain_active && !r_tile_done) begin
               w_tile_step = 1'b1;
               w_state_nxt = w_tile_last ? DRAIN : ACCUM;
            end
         end
         DRAIN: if (w_drain_last) w_state_nxt = FIN;
         FIN:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cfg_passes <= '0;
         r_cfg_tiles  <= '0;
         r_col        <= '0;
         r_pass       <= '0;
         r_tile       <= '0;
         r_flush      <= '0;
         r_odd        <= 1'b0;
         r_tile_done  <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_tile_done <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_cfg_passes <= cfg_passes;
                  r_cfg_tiles  <= cfg_tiles;
                  r_col        <= '0;
                  r_pass       <= '0;
                  r_tile       <= '0;
                  r_flush      <= '0;
                  r_odd        <= 1'b0;
               end
            end
            INIT: r_col <= w_col_last ? '0 : r_col + CW'(1);
            ACCUM: begin
               r_flush <= '0;
               if (p_valid_data) begin
                  if (w_col_last) begin
                     r_col  <= '0;
                     r_pass <= w_pass_last ? '0 : r_pass + PASS_W'(1);
                  end else begin
                     r_col <= r_col + CW'(1);
                  end
               end
            end
            FLUSH: begin
               if (w_tile_step) begin
                  r_odd       <= ~r_odd;
                  r_tile_done <= 1'b1;
                  r_tile      <= w_tile_last ? '0 : r_tile + TILE_W'(1);
                  r_flush     <= '0;
               end else if (!w_flush_end) begin
                  r_flush <= r_flush + 2'd1;
               end
            end
            FIN: r_done <= 1'b1;
            default: ;
         endcase
      end
   end

   // Drain sequencer, launched by the tile_done pulse and free-running for one row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_drain_active <= 1'b0;
         r_drain_cnt    <= '0;
      end else if (r_tile_done) begin
         r_drain_active <= 1'b1;
         r_drain_cnt    <= '0;
      end else if (r_drain_active) begin
         if (w_drain_last) begin
            r_drain_active <= 1'b0;
            r_drain_cnt    <= '0;
         end else begin
            r_drain_cnt <= r_drain_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_psum_ctrl.sv
// Self-checking bench for psum_ctrl: per-cycle outputs against a timeline model.
module tb_psum_ctrl;

   localparam int R    = 4;
   localparam int MAXC = 512;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  cfg_passes;
   logic [15:0] cfg_tiles;
   logic        pe_valid;
   logic        pe_ready, p_init, p_valid_data, p_write_zero;
   logic        odd_cnt, busy, tile_done, done;
   logic [7:0]  w_obs;

   int total = 0;
   int bad   = 0;

   bit       pv [MAXC];
   logic [7:0] exp_vec [MAXC];
   bit       model_odd;
   int       g_first_pwz, g_done, g_pvd, g_td, g_pwz, g_ndone;

   psum_ctrl #(.ROW_LEN(R), .PASS_W(8), .TILE_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .cfg_passes   (cfg_passes),
      .cfg_tiles    (cfg_tiles),
      .pe_valid     (pe_valid),
      .pe_ready     (pe_ready),
      .p_init       (p_init),
      .p_valid_data (p_valid_data),
      .p_write_zero (p_write_zero),
      .odd_cnt      (odd_cnt),
      .busy         (busy),
      .tile_done    (tile_done),
      .done         (done)
   );

   assign w_obs = {pe_ready, p_init, p_valid_data, p_write_zero, odd_cnt, busy, tile_done, done};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic gen_pv(input int mode);
      for (int c = 0; c < MAXC; c++) begin
         case (mode)
            0:       pv[c] = 1'b1;
            1:       pv[c] = (c % 2) == 1;
            default: pv[c] = ($urandom_range(0, 3) != 0) || (c >= 300);
         endcase
      end
   endtask

   // Timeline: INIT at cycles 1..R, accumulate until R*P beats have transferred,
   // 3 flush cycles, then wait for the previous drain; odd toggles / tile_done the
   // cycle after the decision, drain the cycle after that; last tile adds FIN + done.
   task automatic build_model(input int passes, input int tiles, output int done_c);
      int P, N, t, c, L, T, tprev, cnt, ntg;
      int tg [$];
      bit rdy [MAXC];
      bit pwz [MAXC];
      bit td  [MAXC];
      bit odd;
      P = (passes == 0) ? 1 : passes;
      N = (tiles  == 0) ? 1 : tiles;
      for (int i = 0; i < MAXC; i++) begin rdy[i] = 0; pwz[i] = 0; td[i] = 0; end
      t = R + 1; tprev = -1000; T = 0;
      for (int k = 0; k < N; k++) begin
         cnt = 0; c = t;
         while (cnt < R * P && c < MAXC) begin
            rdy[c] = 1;
            if (pv[c]) cnt++;
            c++;
         end
         L = c - 1;
         T = (L + 3 > tprev + R + 2) ? L + 3 : tprev + R + 2;
         if (k == 0) g_first_pwz = T + 2;
         td[T + 1] = 1;
         for (int i = T + 2; i <= T + R + 1; i++) pwz[i] = 1;
         tg.push_back(T + 1);
         tprev = T; t = T + 1;
      end
      done_c = T + R + 3;
      for (int c2 = 0; c2 < MAXC; c2++) begin
         if (c2 == 0) odd = model_odd;
         else begin
            ntg = 0;
            foreach (tg[j]) if (tg[j] <= c2) ntg++;
            odd = (ntg % 2) == 1;
         end
         exp_vec[c2] = {rdy[c2], (c2 >= 1 && c2 <= R), rdy[c2] & pv[c2], pwz[c2], odd,
                        (c2 >= 1 && c2 < done_c), td[c2], (c2 == done_c)};
      end
      model_odd = (N % 2) == 1;
   endtask

   // extra: cycle of a second start pulse (-1 none, -2 random while busy)
   task automatic run_job(input int passes, input int tiles, input int extra, input bit abort_drain);
      int dc, abort, d_done, n_pvd, n_td, n_pwz, n_dn, run, xs;
      build_model(passes, tiles, dc);
      abort = abort_drain ? g_first_pwz + 1 : -1;
      xs = (extra == -2) ? $urandom_range(1, dc - 1) : extra;
      d_done = -1; n_pvd = 0; n_td = 0; n_pwz = 0; n_dn = 0; run = 0;
      cfg_passes = 8'(passes);
      cfg_tiles  = 16'(tiles);
      for (int c = 0; c <= dc + 2; c++) begin
         start    = (c == 0) || (c == xs);
         pe_valid = pv[c];
         @(negedge clk);
         chk($sformatf("outs@%0d", c), 32'(w_obs), 32'(exp_vec[c]));
         if (done) begin n_dn++; if (d_done < 0) d_done = c; end
         if (p_valid_data) n_pvd++;
         if (tile_done) n_td++;
         if (p_write_zero) begin n_pwz++; run++; end
         else if (run != 0) begin chk("drain_len", 32'(run), 32'(R)); run = 0; end
         if (c == abort) begin
            #1 rst_n = 1'b0;
            #1 chk("async_rst", 32'(w_obs), 32'd0);
            @(posedge clk);
            #1 rst_n = 1'b1;
            start = 1'b0;
            model_odd = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      g_done = d_done; g_pvd = n_pvd; g_td = n_td; g_pwz = n_pwz; g_ndone = n_dn;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; pe_valid = 1'b0;
      cfg_passes = '0; cfg_tiles = '0;
      model_odd = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", 32'(w_obs), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      gen_pv(0);
      run_job(2, 1, -1, 1'b0);
      chk("r4p2_done_cycle", 32'(g_done), 32'd22);
      chk("r4p2_first_pwz", 32'(g_first_pwz), 32'd17);
      chk("r4p2_beats", 32'(g_pvd), 32'd8);

      gen_pv(0);
      run_job(1, 3, -1, 1'b0);
      chk("t3_tile_done", 32'(g_td), 32'd3);
      chk("t3_pwz_cycles", 32'(g_pwz), 32'd12);

      gen_pv(1);
      run_job(3, 2, -1, 1'b0);
      chk("toggle_beats", 32'(g_pvd), 32'd24);

      gen_pv(0);
      run_job(0, 0, -1, 1'b0);
      chk("zero_cfg_beats", 32'(g_pvd), 32'd4);
      chk("zero_cfg_tiles", 32'(g_td), 32'd1);

      gen_pv(2);
      run_job(2, 2, 9, 1'b0);
      chk("busy_start_done_cnt", 32'(g_ndone), 32'd1);

      gen_pv(0);
      run_job(1, 2, -1, 1'b1);
      gen_pv(0);
      run_job(1, 1, -1, 1'b0);
      chk("post_rst_done", 32'(g_ndone), 32'd1);

      for (int j = 0; j < 6; j++) begin
         int p, t;
         p = $urandom_range(0, 3);
         t = $urandom_range(0, 3);
         gen_pv(2);
         run_job(p, t, ($urandom_range(0, 1) == 1) ? -2 : -1, 1'b0);
         chk("rand_done_cnt", 32'(g_ndone), 32'd1);
         chk("rand_beats", 32'(g_pvd),
             32'(R * ((p == 0) ? 1 : p) * ((t == 0) ? 1 : t)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
